// File: rtl/modexp_sequencer_if.sv
// modexp_sequencer_if: command, acknowledge and enable bundle between host/datapath and the sequencer
interface modexp_sequencer_if #(
  parameter int EXP_WIDTH = 32,
  localparam int IDX_W = $clog2(EXP_WIDTH)
);
  logic             start;
  logic [1:0]       op;
  logic             init_ack;
  logic             mul_ack;
  logic             mod_ack;
  logic             exp_bit;
  logic [IDX_W-1:0] bit_idx;
  logic             busy;
  logic             initialize;
  logic             en_square;
  logic             en_multiply;
  logic             en_modulo;
  logic             update_e;
  logic             update_n;
  logic             done;
  logic             cmd_err;
  modport master (
    output start, op, init_ack, mul_ack, mod_ack, exp_bit,
    input  bit_idx, busy, initialize, en_square, en_multiply, en_modulo,
           update_e, update_n, done, cmd_err
  );
  modport slave (
    input  start, op, init_ack, mul_ack, mod_ack, exp_bit,
    output bit_idx, busy, initialize, en_square, en_multiply, en_modulo,
           update_e, update_n, done, cmd_err
  );
endinterface

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: left-to-right square-and-multiply control FSM with exponent bit counter
module modexp_sequencer #(
  parameter int EXP_WIDTH = 32,
  localparam int IDX_W = $clog2(EXP_WIDTH)
) (
  input logic clk,
  input logic rst,
  modexp_sequencer_if.slave s
);
  typedef enum logic [3:0] {
    IDLE, INIT, SQUARE, SQ_MOD, MULT, MUL_MOD, DONE, UPD_E, UPD_N
  } state_e;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(EXP_WIDTH - 1);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             cmd_err_q, cmd_err_d;
  logic             last;
  assign last = bit_idx_q == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= TOP_IDX;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      cmd_err_q <= cmd_err_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    cmd_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d   = !s.start         ? IDLE  :
                    s.op == 2'b00    ? INIT  :
                    s.op == 2'b01    ? UPD_E :
                    s.op == 2'b10    ? UPD_N : IDLE;
        cmd_err_d = s.start && s.op == 2'b11;
      end
      INIT: begin
        bit_idx_d = TOP_IDX;
        state_d   = s.init_ack ? SQUARE : INIT;
      end
      SQUARE: state_d = s.mul_ack ? SQ_MOD : SQUARE;
      // exp_bit is only meaningful on the cycle the squared value is reduced
      SQ_MOD: if (s.mod_ack) begin
        state_d   = s.exp_bit ? MULT : last ? DONE : SQUARE;
        bit_idx_d = (!s.exp_bit && !last) ? bit_idx_q - IDX_W'(1) : bit_idx_q;
      end
      MULT: state_d = s.mul_ack ? MUL_MOD : MULT;
      MUL_MOD: if (s.mod_ack) begin
        state_d   = last ? DONE : SQUARE;
        bit_idx_d = last ? bit_idx_q : bit_idx_q - IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    s.bit_idx     = bit_idx_q;
    s.busy        = state_q != IDLE;
    s.initialize  = state_q == INIT;
    s.en_square   = state_q == SQUARE;
    s.en_multiply = state_q == MULT;
    s.en_modulo   = state_q == SQ_MOD || state_q == MUL_MOD;
    s.update_e    = state_q == UPD_E;
    s.update_n    = state_q == UPD_N;
    s.done        = state_q == DONE;
    s.cmd_err     = cmd_err_q;
  end
endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: directed checks of the sequencer with EXP_WIDTH=4 and a tiny datapath model
module tb_modexp_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] e_reg;
  int stall;
  int mcnt = 0;
  int n_cmp = 0;
  int n_err = 0;
  modexp_sequencer_if #(.EXP_WIDTH(4)) bus ();
  modexp_sequencer #(.EXP_WIDTH(4)) dut (.clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;
  assign bus.exp_bit = e_reg[bus.bit_idx];
  // multiplier model: acknowledges after 'stall' extra cycles of a held enable
  always @(posedge clk) mcnt <= ((bus.en_square || bus.en_multiply) && !bus.mul_ack) ? mcnt + 1 : 0;
  assign bus.mul_ack = (stall == 0) || (mcnt >= stall);
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int outs();
    return {bus.initialize, bus.en_square, bus.en_multiply, bus.en_modulo,
            bus.update_e, bus.update_n, bus.done, bus.cmd_err};
  endfunction
  task automatic run_exp(input logic [3:0] ev, input int inj, output int done_at,
                         output int mul_cyc, output int stray, output int unstable,
                         output int seq, output int busy_after);
    logic prev_sq, prev_mul;
    logic [1:0] prev_idx;
    logic [7:0] sq;
    e_reg = ev; done_at = 0; mul_cyc = 0; stray = 0; unstable = 0; sq = '0;
    prev_sq = 1'b0; prev_mul = 1'b0; prev_idx = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00;
    for (int k = 1; k <= 80 && done_at == 0; k++) begin
      @(negedge clk);
      bus.start = k == inj;
      bus.op = (k == inj) ? 2'b01 : 2'b00;
      if (bus.done) done_at = k;
      if (bus.en_multiply) mul_cyc++;
      if (bus.update_e || bus.update_n || bus.cmd_err) stray++;
      if (bus.en_square && !prev_sq) sq = {sq[5:0], bus.bit_idx};
      if (((bus.en_square && prev_sq) || (bus.en_multiply && prev_mul)) && bus.bit_idx != prev_idx) unstable++;
      prev_sq = bus.en_square; prev_mul = bus.en_multiply; prev_idx = bus.bit_idx;
    end
    seq = sq;
    bus.start = 1'b0;
    @(negedge clk);
    busy_after = bus.busy;
  endtask
  initial begin
    int done_at, mul_cyc, stray, unstable, seq, busy_after;
    logic found, prev_mul;
    rst = 1'b1; bus.start = 1'b0; bus.op = 2'b00; bus.init_ack = 1'b1; bus.mod_ack = 1'b1;
    stall = 0; e_reg = '0;
    repeat (2) @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst bit_idx", bus.bit_idx, 3);
    check("rst outs", outs(), 0);
    rst = 1'b0;
    run_exp(4'b1011, 0, done_at, mul_cyc, stray, unstable, seq, busy_after);
    check("e1011 done cycle", done_at, 16);
    check("e1011 mult cycles", mul_cyc, 3);
    check("e1011 idx seq", seq, 8'hE4);
    check("e1011 busy after", busy_after, 0);
    check("e1011 stray pulses", stray, 0);
    run_exp(4'b0000, 0, done_at, mul_cyc, stray, unstable, seq, busy_after);
    check("e0 done cycle", done_at, 10);
    check("e0 mult cycles", mul_cyc, 0);
    check("e0 idx seq", seq, 8'hE4);
    stall = 3;
    run_exp(4'b1011, 0, done_at, mul_cyc, stray, unstable, seq, busy_after);
    check("stall done cycle", done_at, 37);
    check("stall mult cycles", mul_cyc, 12);
    check("stall idx seq", seq, 8'hE4);
    check("stall idx stable", unstable, 0);
    stall = 0;
    run_exp(4'b0000, 2, done_at, mul_cyc, stray, unstable, seq, busy_after);
    check("busy start ignored done", done_at, 10);
    check("busy start ignored stray", stray, 0);
    @(negedge clk); bus.start = 1'b1; bus.op = 2'b01;
    @(negedge clk); bus.start = 1'b0;
    check("upd_e pulse", bus.update_e, 1);
    check("upd_e busy", bus.busy, 1);
    check("upd_e no n", bus.update_n, 0);
    @(negedge clk);
    check("upd_e clear", bus.update_e, 0);
    check("upd_e idle", bus.busy, 0);
    bus.start = 1'b1; bus.op = 2'b10;
    @(negedge clk); bus.start = 1'b0;
    check("upd_n pulse", bus.update_n, 1);
    @(negedge clk);
    check("upd_n clear", bus.update_n, 0);
    check("upd_n idle", bus.busy, 0);
    bus.start = 1'b1; bus.op = 2'b11;
    @(negedge clk); bus.start = 1'b0;
    check("cmd_err pulse", bus.cmd_err, 1);
    check("cmd_err busy", bus.busy, 0);
    @(negedge clk);
    check("cmd_err clear", bus.cmd_err, 0);
    e_reg = 4'b1111; found = 1'b0; prev_mul = 1'b0;
    bus.start = 1'b1; bus.op = 2'b00;
    for (int k = 1; k <= 30 && !found; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.en_modulo && bus.bit_idx == 2 && prev_mul) found = 1'b1;
      else prev_mul = bus.en_multiply;
    end
    check("reach mul_mod idx2", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", bus.busy, 0);
    check("abort bit_idx", bus.bit_idx, 3);
    check("abort outs", outs(), 0);
    rst = 1'b0;
    e_reg = 4'b0000; done_at = 0;
    bus.start = 1'b1; bus.op = 2'b00;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge clk);
      if (bus.done) done_at = k;
    end
    check("held start done cycle", done_at, 10);
    @(negedge clk);
    check("held start idle", bus.busy, 0);
    @(negedge clk);
    check("held start restart", bus.initialize, 1);
    bus.start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
